// File: rtl/multi_mem_master.sv
// multi_mem_master: initiator-side data-memory controller for the multi-cycle CPU.
// Turns a CPU request (byte address, store data, size) into timed cycles on a
// registered-read memory (addra/wea/rea/dina/douta) and returns load data with
// a one-cycle done pulse. All outputs are registered.
//
// Optional feature macro: MULTI_MEM_SUBWORD_EN
//   defined   : byte/half loads (lane shifted down, zero-extended) and byte/half
//               stores via read-modify-write (RMW_RD then RMW_WR).
//   undefined : only word accesses are legal; any other size returns err.
//
// Handshake: req is accepted on a posedge while busy=0 (state IDLE). done pulses
// for one cycle with busy already low, so a held req is accepted on the edge that
// ends the done cycle. A req seen while busy=1 is dropped, never queued.
module multi_mem_master #(
    parameter int RD_LAT = 2,
    parameter int AW     = 10
) (
    input  logic          clka,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    input  logic [1:0]    size,
    output logic [31:0]   rdata,
    output logic          done,
    output logic          busy,
    output logic          err,
    output logic [AW-1:0] mem_addra,
    output logic          mem_wea,
    output logic          mem_rea,
    output logic [31:0]   mem_dina,
    input  logic [31:0]   mem_douta
);

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR} state_t;

    localparam logic [2:0] CNT_LAST = 3'(RD_LAT - 1);

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [AW-1:0] addra_q, addra_d;
    logic          wea_q, wea_d;
    logic          rea_q, rea_d;
    logic [31:0]   dina_q, dina_d;
    logic          legal;

    // Upper address bits are deliberately dropped: the address space wraps.
    logic          unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW+2];

`ifdef MULTI_MEM_SUBWORD_EN
    logic [1:0]    addr_lo_q, addr_lo_d;
    logic [1:0]    size_q, size_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [31:0]   lane_shift, load_word, rmw_word;

    // Lane extraction for subword loads and lane merge for subword stores.
    always_comb begin
        lane_shift = mem_douta >> {addr_lo_q, 3'b000};
        case (size_q)
            2'b00:   load_word = {24'h0, lane_shift[7:0]};
            2'b01:   load_word = {16'h0, lane_shift[15:0]};
            default: load_word = mem_douta;
        endcase
        rmw_word = mem_douta;
        if (size_q == 2'b00) rmw_word[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
        else                 rmw_word[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q;
    end
`endif

    // Request legality: alignment per size; the reserved size is never legal.
    always_comb begin
`ifdef MULTI_MEM_SUBWORD_EN
        case (size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~addr[0];
            2'b10:   legal = (addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
`else
        legal = (size == 2'b10) && (addr[1:0] == 2'b00);
`endif
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = err_q;
        addra_d = addra_q;
        wea_d   = 1'b0;
        rea_d   = 1'b0;
        dina_d  = dina_q;
`ifdef MULTI_MEM_SUBWORD_EN
        addr_lo_d = addr_lo_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!legal) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        addra_d = addr[AW+1:2];
                        cnt_d   = 3'd0;
`ifdef MULTI_MEM_SUBWORD_EN
                        addr_lo_d = addr[1:0];
                        size_d    = size;
                        wdata_d   = wdata[15:0];
`endif
                        if (!we) begin
                            state_d = RD;
                            rea_d   = 1'b1;
                        end else if (size == 2'b10) begin
                            state_d = WR;
                            wea_d   = 1'b1;
                            dina_d  = wdata;
                        end else begin
`ifdef MULTI_MEM_SUBWORD_EN
                            state_d = RMW_RD;
                            rea_d   = 1'b1;
`endif
                        end
                    end
                end
            end
            RD: begin
                rea_d = 1'b1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == CNT_LAST) begin
                    rea_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef MULTI_MEM_SUBWORD_EN
                    rdata_d = load_word;
`else
                    rdata_d = mem_douta;
`endif
                end
            end
            WR: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
`ifdef MULTI_MEM_SUBWORD_EN
            RMW_RD: begin
                rea_d = 1'b1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == CNT_LAST) begin
                    rea_d   = 1'b0;
                    wea_d   = 1'b1;
                    dina_d  = rmw_word;
                    state_d = RMW_WR;
                end
            end
            RMW_WR: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rdata_q <= 32'h0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            addra_q <= '0;
            wea_q   <= 1'b0;
            rea_q   <= 1'b0;
            dina_q  <= 32'h0;
`ifdef MULTI_MEM_SUBWORD_EN
            addr_lo_q <= 2'b00;
            size_q    <= 2'b00;
            wdata_q   <= 16'h0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            addra_q <= addra_d;
            wea_q   <= wea_d;
            rea_q   <= rea_d;
            dina_q  <= dina_d;
`ifdef MULTI_MEM_SUBWORD_EN
            addr_lo_q <= addr_lo_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
`endif
        end
    end

    assign rdata     = rdata_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign mem_addra = addra_q;
    assign mem_wea   = wea_q;
    assign mem_rea   = rea_q;
    assign mem_dina  = dina_q;

endmodule
